alu_bist: RTL and testbench

Built-in self-test controller for the datapath ALU. It sits on the ALU's operand and control side, in place of the instruction decoder during test. It drives pseudo-random operands A/B and cycles the 3-bit function code F through every value, sampling Y/zero/OF each vector. It compacts the results into a multiple-input signature register (MISR) and reports pass/fail against a golden signature, so ALU coverage can be checked on silicon or FPGA without a software testbench.

---
 rtl/alu_bist.sv | 157 +++++++++++++++
 tb/tb_alu_bist.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_bist.sv
// Built-in self-test controller for the datapath ALU: drives LFSR operands and a cycling
// function code, compacts Y/zero/OF into a MISR and compares against a golden signature.
module alu_bist #(
   parameter int              N           = 32,
   parameter int              NUM_VECTORS = 256,
   parameter logic [N-1:0]    POLY        = 32'h80200003,
   parameter logic [N-1:0]    SEED_A      = 32'h00000001,
   parameter logic [N-1:0]    SEED_B      = 32'hACE1ACE1,
   parameter logic [N-1:0]    GOLDEN_SIG  = 32'h00000000,
   localparam int             VW          = $clog2(NUM_VECTORS + 1)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   output logic [N-1:0]  A,
   output logic [N-1:0]  B,
   output logic [2:0]    F,
   input  logic [N-1:0]  Y,
   input  logic          zero,
   input  logic          OF,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [N-1:0]  signature,
   output logic [VW-1:0] vec_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // An all-zero LFSR never leaves zero, so a zero seed is promoted to 1.
   localparam logic [N-1:0]  ONE_N      = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0]  SEED_A_EFF = (SEED_A == {N{1'b0}}) ? ONE_N : SEED_A;
   localparam logic [N-1:0]  SEED_B_EFF = (SEED_B == {N{1'b0}}) ? ONE_N : SEED_B;
   localparam logic [VW-1:0] LAST_CNT   = VW'(NUM_VECTORS - 1);

   function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
      return (s >> 1) ^ (s[0] ? POLY : {N{1'b0}});
   endfunction

   state_t        state_r, state_s;
   logic [N-1:0]  a_r, a_s, b_r, b_s, sig_r, sig_s, misr_s;
   logic [2:0]    f_r, f_s;
   logic [VW-1:0] cnt_r, cnt_s;
   logic          busy_r, busy_s, done_r, done_s, pass_r, pass_s;
   logic          last_s;

   assign last_s = (cnt_r == LAST_CNT);
   assign misr_s = lfsr_step(sig_r) ^ Y ^ {zero, {(N-1){1'b0}}} ^ {1'b0, OF, {(N-2){1'b0}}};

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode; start is only honoured from IDLE or DONE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    if (start) state_s = APPLY;  else state_s = IDLE;
         APPLY:   state_s = SAMPLE;
         SAMPLE:  if (last_s) state_s = DONE;  else state_s = APPLY;
         DONE:    if (start) state_s = APPLY;  else state_s = DONE;
         default: state_s = IDLE;
      endcase
   end

   // Next values of the operand, signature and status registers.
   always_comb begin
      a_s    = a_r;
      b_s    = b_r;
      f_s    = f_r;
      sig_s  = sig_r;
      cnt_s  = cnt_r;
      busy_s = busy_r;
      done_s = done_r;
      pass_s = pass_r;
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               a_s    = SEED_A_EFF;
               b_s    = SEED_B_EFF;
               f_s    = 3'd0;
               sig_s  = {N{1'b0}};
               cnt_s  = {VW{1'b0}};
               busy_s = 1'b1;
               done_s = 1'b0;
               pass_s = 1'b0;
            end else begin
               busy_s = 1'b0;
            end
         end
         APPLY: begin
            busy_s = 1'b1;
         end
         SAMPLE: begin
            sig_s = misr_s;
            cnt_s = cnt_r + VW'(1'b1);
            if (last_s) begin
               busy_s = 1'b0;
               done_s = 1'b1;
               pass_s = (misr_s == GOLDEN_SIG);
            end else begin
               a_s = lfsr_step(a_r);
               b_s = lfsr_step(b_r);
               f_s = f_r + 3'd1;
            end
         end
         default: begin
            busy_s = 1'b0;
            done_s = 1'b0;
            pass_s = 1'b0;
         end
      endcase
   end

   // Datapath and status registers; every output comes straight from here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_r    <= {N{1'b0}};
         b_r    <= {N{1'b0}};
         f_r    <= 3'd0;
         sig_r  <= {N{1'b0}};
         cnt_r  <= {VW{1'b0}};
         busy_r <= 1'b0;
         done_r <= 1'b0;
         pass_r <= 1'b0;
      end else begin
         a_r    <= a_s;
         b_r    <= b_s;
         f_r    <= f_s;
         sig_r  <= sig_s;
         cnt_r  <= cnt_s;
         busy_r <= busy_s;
         done_r <= done_s;
         pass_r <= pass_s;
      end
   end

   assign A         = a_r;
   assign B         = b_r;
   assign F         = f_r;
   assign signature = sig_r;
   assign vec_count = cnt_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign pass      = pass_r;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: three instances (4, 1 and 9 vectors) share stimulus and are
// checked against hand-computed LFSR/MISR values.
module tb_alu_bist;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] y;
   logic        zero;
   logic        of;

   int checks   = 0;
   int failures = 0;

   logic [31:0] a4, b4, sig4, a1, b1, sig1, a9, b9, sig9;
   logic [2:0]  f4, f1, f9;
   logic        busy4, done4, pass4, busy1, done1, pass1, busy9, done9, pass9;
   logic [2:0]  cnt4;
   logic [0:0]  cnt1;
   logic [3:0]  cnt9;

   always #5 clk = ~clk;

   alu_bist #(.NUM_VECTORS(4)) u4 (
      .clk(clk), .reset_n(reset_n), .start(start), .A(a4), .B(b4), .F(f4),
      .Y(y), .zero(zero), .OF(of), .busy(busy4), .done(done4), .pass(pass4),
      .signature(sig4), .vec_count(cnt4)
   );

   // Zero seed must be promoted to 1; golden matches the flag-folding result.
   alu_bist #(.NUM_VECTORS(1), .SEED_A(32'h00000000), .GOLDEN_SIG(32'hC0000000)) u1 (
      .clk(clk), .reset_n(reset_n), .start(start), .A(a1), .B(b1), .F(f1),
      .Y(y), .zero(zero), .OF(of), .busy(busy1), .done(done1), .pass(pass1),
      .signature(sig1), .vec_count(cnt1)
   );

   alu_bist #(.NUM_VECTORS(9)) u9 (
      .clk(clk), .reset_n(reset_n), .start(start), .A(a9), .B(b9), .F(f9),
      .Y(y), .zero(zero), .OF(of), .busy(busy9), .done(done9), .pass(pass9),
      .signature(sig9), .vec_count(cnt9)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      y       = 32'h0;
      zero    = 1'b0;
      of      = 1'b0;
      #12;
      chk("rst_a", a4, 32'h0);
      chk("rst_busy", {31'b0, busy4}, 32'h0);
      chk("rst_done", {31'b0, done4}, 32'h0);
      chk("rst_sig", sig4, 32'h0);
      reset_n = 1'b1;
      ticks(2);
      chk("idle_busy", {31'b0, busy4}, 32'h0);

      // Operand sequence with a stubbed all-zero ALU.
      pulse_start();
      chk("v0_a", a4, 32'h00000001);
      chk("v0_b", b4, 32'hACE1ACE1);
      chk("v0_f", {29'b0, f4}, 32'd0);
      chk("v0_busy", {31'b0, busy4}, 32'h1);
      chk("v0_cnt", {29'b0, cnt4}, 32'd0);
      chk("seed0_a", a1, 32'h00000001);
      tick();
      chk("v0_a_stable", a4, 32'h00000001);
      tick();
      chk("v1_a", a4, 32'h80200003);
      chk("v1_b", b4, 32'hD650D673);
      chk("v1_f", {29'b0, f4}, 32'd1);
      chk("v1_cnt", {29'b0, cnt4}, 32'd1);
      chk("n1_done", {31'b0, done1}, 32'h1);
      chk("n1_busy", {31'b0, busy1}, 32'h0);
      chk("n1_pass", {31'b0, pass1}, 32'h0);
      ticks(2);
      chk("v2_a", a4, 32'hC0300002);
      chk("v2_f", {29'b0, f4}, 32'd2);
      ticks(2);
      chk("v3_a", a4, 32'h60180001);
      chk("v3_f", {29'b0, f4}, 32'd3);
      tick();
      chk("done_edge7", {31'b0, done4}, 32'h0);
      tick();
      chk("done_edge8", {31'b0, done4}, 32'h1);
      chk("busy_edge8", {31'b0, busy4}, 32'h0);
      chk("zero_sig", sig4, 32'h0);
      chk("zero_pass", {31'b0, pass4}, 32'h1);
      chk("final_cnt", {29'b0, cnt4}, 32'd4);
      chk("final_a_hold", a4, 32'h60180001);
      ticks(9);
      chk("n9_not_done", {31'b0, done9}, 32'h0);
      tick();
      chk("n9_done", {31'b0, done9}, 32'h1);
      chk("n9_a", a9, 32'hDB36C002);
      chk("n9_f_wrap", {29'b0, f9}, 32'd0);
      chk("n9_cnt", {28'b0, cnt9}, 32'd9);
      chk("n4_done_hold", {31'b0, done4}, 32'h1);

      // MISR folding with Y=1; restart from DONE reinitialises everything.
      y = 32'h00000001;
      pulse_start();
      chk("restart_done", {31'b0, done4}, 32'h0);
      chk("restart_pass", {31'b0, pass4}, 32'h0);
      chk("restart_sig", sig4, 32'h0);
      chk("restart_a", a4, 32'h00000001);
      ticks(2);
      chk("misr_v0", sig4, 32'h00000001);
      ticks(2);
      chk("misr_v1", sig4, 32'h80200002);
      start = 1'b1;
      ticks(2);
      start = 1'b0;
      chk("ignored_start_cnt", {29'b0, cnt4}, 32'd3);
      chk("misr_v2", sig4, 32'h40100000);
      ticks(2);
      chk("misr_done", {31'b0, done4}, 32'h1);
      chk("misr_final", sig4, 32'h20080001);
      chk("misr_pass", {31'b0, pass4}, 32'h0);

      // Flag folding: zero lands in bit 31, OF in bit 30.
      y    = 32'h0;
      zero = 1'b1;
      of   = 1'b1;
      pulse_start();
      ticks(2);
      chk("flag_n1_sig", sig1, 32'hC0000000);
      chk("flag_n1_pass", {31'b0, pass1}, 32'h1);
      chk("flag_v0", sig4, 32'hC0000000);
      ticks(6);
      chk("flag_final", sig4, 32'h88000000);

      // Asynchronous reset mid-APPLY, no clock edge in between.
      zero = 1'b0;
      of   = 1'b0;
      pulse_start();
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_a", a4, 32'h0);
      chk("arst_b", b4, 32'h0);
      chk("arst_f", {29'b0, f4}, 32'd0);
      chk("arst_busy", {31'b0, busy4}, 32'h0);
      chk("arst_done", {31'b0, done9}, 32'h0);
      chk("arst_pass", {31'b0, pass1}, 32'h0);
      chk("arst_cnt", {29'b0, cnt4}, 32'd0);
      #3;
      reset_n = 1'b1;
      tick();
      y = 32'h00000001;
      pulse_start();
      chk("replay_a", a4, 32'h00000001);
      chk("replay_f", {29'b0, f4}, 32'd0);
      chk("replay_sig", sig4, 32'h0);
      ticks(2);
      chk("replay_misr_v0", sig4, 32'h00000001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
